cmd_frm_rcv: RTL and testbench

- Serial command-frame receiver, directly upstream of the digital core.
- Deserialises 8N1 UART bytes from the host link and assembles 3 bytes into a 24-bit command word.
- Presents the word on cfg_data with a frm_rdy flag; the core's math state machine consumes it and acknowledges with clr_rdy.
- Guards against partial frames with an inter-byte gap timeout and against line corruption with framing-error detection.

---
 rtl/cmd_frm_rcv.sv | 190 +++++++++++++++++++
 tb/tb_cmd_frm_rcv.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frm_rcv.sv
// cmd_frm_rcv: serial command-frame receiver. Deserialises 8N1 bytes from
// the host link and assembles three of them into a 24-bit command word
// (byte0 in [23:16]) presented with a ready flag.
// Optional build macro FRM_PARITY_EN switches the link format to 8E1 and
// adds parity checking; without it the receiver is plain 8N1.
module cmd_frm_rcv #(
    parameter int BAUD_DIV = 2604,  // clocks per bit, 8..65535
    parameter int GAP_BITS = 20     // idle bit-times tolerated inside a frame
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_rdy,
    output logic [23:0] cfg_data,
    output logic        frm_rdy,
    output logic        frm_err
);

    localparam int BW      = $clog2(BAUD_DIV);
    localparam int GAP_LIM = GAP_BITS * BAUD_DIV;
    localparam int GW      = $clog2(GAP_LIM + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LIM - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_LIM);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef FRM_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    logic          r_sync1, r_sync2;
    state_t        r_state, w_next;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [1:0]    r_byte_cnt;
    logic [7:0]    r_stage0, r_stage1;
    logic [GW-1:0] r_gap_cnt;
    logic [23:0]   r_cfg;
    logic          r_rdy, r_err;

    logic w_rx, w_tick, w_byte_ok, w_err_set, w_frm_done, w_gap_exp, w_par_ok;

    assign w_rx = r_sync2;

    // Two-flop synchroniser for the asynchronous RX line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let r_sync2 take the previous r_sync1, forming a real two-stage chain.
            r_sync1 <= RX;
            r_sync2 <= r_sync1;
        end
    end

    // Bit state machine: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Bit state machine: next-state decode.
    always_comb begin
        // NOTE: default first, so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (!w_rx)  w_next = S_START;
            S_START:   if (w_tick) w_next = w_rx ? S_IDLE : S_DATA;
`ifdef FRM_PARITY_EN
            S_DATA:    if (w_tick && r_bit_cnt == 3'd7) w_next = S_PARITY;
            S_PARITY:  if (w_tick) w_next = S_STOP;
`else
            S_DATA:    if (w_tick && r_bit_cnt == 3'd7) w_next = S_STOP;
`endif
            S_STOP:    if (w_tick) w_next = w_rx ? S_IDLE : S_WAIT_HI;
            S_WAIT_HI: if (w_rx)   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Bit state machine: sample strobe, byte-accept and error strobes.
    always_comb begin
        w_tick    = (r_state == S_START) ? (r_baud_cnt == HALF_LAST)
                                         : (r_baud_cnt == BIT_LAST);
        w_byte_ok = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
`ifdef FRM_PARITY_EN
            S_PARITY: w_err_set = w_tick && (^{r_shift, w_rx});
`endif
            S_STOP: begin
                w_byte_ok = w_tick && w_rx && w_par_ok;
                w_err_set = w_tick && !w_rx;
            end
            default: ;
        endcase
        w_frm_done = w_byte_ok && (r_byte_cnt == 2'd2);
        w_gap_exp  = (r_state == S_IDLE) && (r_byte_cnt != 2'd0) && (r_gap_cnt == GAP_LAST);
    end

    // Baud counter restarts at each sample; data bits shift in LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            if (r_state == S_IDLE || r_state == S_WAIT_HI || w_tick) r_baud_cnt <= '0;
            else                                                     r_baud_cnt <= r_baud_cnt + BW'(1);
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_DATA && w_tick) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {w_rx, r_shift[7:1]};
            end
        end
    end

`ifdef FRM_PARITY_EN
    logic r_par_err;

    // A parity failure vetoes the byte; the stop bit is still consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_par_err <= 1'b0;
        else if (r_state == S_IDLE) r_par_err <= 1'b0;
        else if (w_err_set && r_state == S_PARITY) r_par_err <= 1'b1;
    end

    assign w_par_ok = !r_par_err;
`else
    assign w_par_ok = 1'b1;
`endif

    // Inter-byte gap timer: runs only while idle inside a partial frame, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_gap_cnt <= '0;
        else if (r_state != S_IDLE) r_gap_cnt <= '0;
        else if (r_byte_cnt != 2'd0 && r_gap_cnt != GAP_MAX) r_gap_cnt <= r_gap_cnt + GW'(1);
    end

    // Frame assembly, ready flag (completion beats clear) and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            // NOTE: the staging bytes are ordinary flops, so they get a reset value like everything else.
            r_stage0   <= '0;
            r_stage1   <= '0;
            r_cfg      <= '0;
            r_rdy      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err_set;
            if (w_byte_ok) begin
                case (r_byte_cnt)
                    2'd0: begin
                        r_stage0   <= r_shift;
                        r_byte_cnt <= 2'd1;
                    end
                    2'd1: begin
                        r_stage1   <= r_shift;
                        r_byte_cnt <= 2'd2;
                    end
                    default: begin
                        r_cfg      <= {r_stage0, r_stage1, r_shift};
                        r_byte_cnt <= 2'd0;
                    end
                endcase
            end else if (w_err_set || w_gap_exp) begin
                r_byte_cnt <= 2'd0;
            end
            if (w_frm_done)   r_rdy <= 1'b1;
            else if (clr_rdy) r_rdy <= 1'b0;
        end
    end

    assign cfg_data = r_cfg;
    assign frm_rdy  = r_rdy;
    assign frm_err  = r_err;

endmodule

// File: tb/tb_cmd_frm_rcv.sv
// tb_cmd_frm_rcv: directed bench for cmd_frm_rcv with an event-level model.
// Each sent byte is turned into an outcome (valid byte / error) scheduled at
// the edge where the receiver must act on it; the model replays those
// outcomes through the frame rules and every cycle is compared.
module tb_cmd_frm_rcv;

    localparam int B   = 16;
    localparam int H   = B / 2;
    localparam int GB  = 20;
    localparam int GAP = GB * B;
`ifdef FRM_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_rdy = 1'b0;
    logic [23:0] cfg_data;
    logic        frm_rdy, frm_err;

    cmd_frm_rcv #(.BAUD_DIV(B), .GAP_BITS(GB)) dut (
        .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
        .cfg_data(cfg_data), .frm_rdy(frm_rdy), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    int cyc = 0;
    int clr_edge = -1;
    bit running = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Scheduled outcomes keyed by the edge number at which they take effect.
    int         ev_kind[int];   // 1 = valid byte, 2 = error
    logic [7:0] ev_byte[int];
    int         ev_det[int];    // edge at which the start bit was detected

    typedef struct packed {
        logic [23:0] cfg;
        logic        rdy;
        logic        err;
        logic [1:0]  cnt;
        int          last;
        logic [7:0]  s0;
        logic [7:0]  s1;
    } model_t;

    model_t m = '0;

    function automatic model_t model_step(input model_t cur, input int c, input logic clr);
        model_t n = cur;
        bit done = 1'b0;
        n.err = 1'b0;
        if (ev_kind.exists(c)) begin
            if (n.cnt != 0 && ev_det[c] - n.last >= GAP) n.cnt = 0;
            if (ev_kind[c] == 1) begin
                n.last = c;
                if (n.cnt == 0) begin n.s0 = ev_byte[c]; n.cnt = 1; end
                else if (n.cnt == 1) begin n.s1 = ev_byte[c]; n.cnt = 2; end
                else begin n.cfg = {n.s0, n.s1, ev_byte[c]}; n.cnt = 0; done = 1'b1; end
            end else begin
                n.err = 1'b1;
                n.cnt = 0;
            end
        end
        if (done)     n.rdy = 1'b1;
        else if (clr) n.rdy = 1'b0;
        return n;
    endfunction

    // Edge counter and model update.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m <= '0;
            ev_kind.delete();
            ev_byte.delete();
            ev_det.delete();
        end else begin
            m <= model_step(m, cyc + 1, clr_rdy);
        end
    end

    // clr_rdy is driven high for exactly the cycle before edge clr_edge.
    always @(posedge clk) begin
        #1;
        clr_rdy = (cyc + 1 == clr_edge);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (running) begin
            if (frm_err === 1'b1) n_pulses++;
            if (rst) begin
                check("reset cfg_data", cfg_data, 0);
                check("reset frm_rdy", frm_rdy, 0);
                check("reset frm_err", frm_err, 0);
            end else begin
                check("cfg_data", cfg_data, m.cfg);
                check("frm_rdy", frm_rdy, m.rdy);
                check("frm_err", frm_err, m.err);
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(posedge clk); #1;
        RX = b;
        repeat (B - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit good_stop, input bit good_par,
                             input bit clr_on_done);
        int c0, e, kind;
        @(posedge clk); #1;
        RX = 1'b0;
        c0 = cyc;
        // sync (2) + detect (1) + half bit to start centre + one bit per later sample
        e = c0 + 3 + H + (NB + 1) * B;
        kind = good_stop ? 1 : 2;
`ifdef FRM_PARITY_EN
        if (!good_par) begin
            kind = 2;
            e = c0 + 3 + H + 9 * B;
        end
`endif
        ev_kind[e] = kind;
        ev_byte[e] = d;
        ev_det[e]  = c0 + 3;
        if (clr_on_done) clr_edge = c0 + 3 + H + (NB + 1) * B;
        repeat (B - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef FRM_PARITY_EN
        drive_bit(good_par ? ^d : ~^d);
`endif
        drive_bit(good_stop);
    endtask

    task automatic line_level(input logic lvl, input int bits);
        @(posedge clk); #1;
        RX = lvl;
        repeat (bits * B - 1) @(posedge clk);
        #1;
    endtask

    task automatic clear_rdy();
        clr_edge = cyc + 2;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        line_level(1'b1, 2);
        check("post-reset frm_rdy", frm_rdy, 0);
        check("post-reset cfg_data", cfg_data, 0);

        // Back-to-back frame, then clear.
        send_byte(8'hA5, 1, 1, 0);
        send_byte(8'h3C, 1, 1, 0);
        send_byte(8'h0F, 1, 1, 0);
        line_level(1'b1, 1);
        check("t1 cfg_data", cfg_data, 24'hA53C0F);
        check("t1 frm_rdy", frm_rdy, 1);
        check("t1 no frm_err", n_pulses, 0);
        clear_rdy();
        check("t1 clr frm_rdy", frm_rdy, 0);
        check("t1 hold cfg_data", cfg_data, 24'hA53C0F);

        // Partial frame dropped by gap timeout.
        send_byte(8'h12, 1, 1, 0);
        send_byte(8'h34, 1, 1, 0);
        line_level(1'b1, 25);
        send_byte(8'h56, 1, 1, 0);
        send_byte(8'h78, 1, 1, 0);
        send_byte(8'h9A, 1, 1, 0);
        line_level(1'b1, 1);
        check("t2 cfg_data", cfg_data, 24'h56789A);
        check("t2 frm_rdy", frm_rdy, 1);
        check("t2 no frm_err", n_pulses, 0);
        clear_rdy();

        // Framing error followed by a held-low line.
        send_byte(8'h11, 0, 1, 0);
        line_level(1'b0, 40);
        line_level(1'b1, 2);
        send_byte(8'h22, 1, 1, 0);
        send_byte(8'h33, 1, 1, 0);
        send_byte(8'h44, 1, 1, 0);
        line_level(1'b1, 1);
        check("t3 one frm_err", n_pulses, 1);
        check("t3 cfg_data", cfg_data, 24'h223344);
        check("t3 frm_rdy", frm_rdy, 1);
        clear_rdy();

        // Short low glitch on an idle line.
        @(posedge clk); #1;
        RX = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        RX = 1'b1;
        line_level(1'b1, 3);
        check("t4 frm_rdy", frm_rdy, 0);
        check("t4 frm_err", n_pulses, 1);

        // Overrun with clear in the completion cycle.
        send_byte(8'h01, 1, 1, 0);
        send_byte(8'h02, 1, 1, 0);
        send_byte(8'h03, 1, 1, 0);
        line_level(1'b1, 1);
        check("t5 first cfg_data", cfg_data, 24'h010203);
        send_byte(8'hAA, 1, 1, 0);
        send_byte(8'hBB, 1, 1, 0);
        send_byte(8'hCC, 1, 1, 1);
        line_level(1'b1, 1);
        check("t5 frm_rdy", frm_rdy, 1);
        check("t5 cfg_data", cfg_data, 24'hAABBCC);

        // Reset in the middle of the second byte.
        send_byte(8'hDE, 1, 1, 0);
        @(posedge clk); #1;
        RX = 1'b0;
        repeat (3 * B) @(posedge clk);
        #1;
        rst = 1'b1;
        RX  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6 rst cfg_data", cfg_data, 0);
        check("t6 rst frm_rdy", frm_rdy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        line_level(1'b1, 2);
        send_byte(8'hDE, 1, 1, 0);
        send_byte(8'hAD, 1, 1, 0);
        send_byte(8'hBE, 1, 1, 0);
        line_level(1'b1, 1);
        check("t6 cfg_data", cfg_data, 24'hDEADBE);
        check("t6 frm_rdy", frm_rdy, 1);

`ifdef FRM_PARITY_EN
        // Wrong parity on the second byte of a frame.
        clear_rdy();
        send_byte(8'h11, 1, 1, 0);
        send_byte(8'h22, 1, 0, 0);
        send_byte(8'h33, 1, 1, 0);
        line_level(1'b1, 1);
        check("t7 parity frm_err", n_pulses, 2);
        check("t7 no frm_rdy", frm_rdy, 0);
        check("t7 cfg_data", cfg_data, 24'hDEADBE);
`endif

        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
